// File: rtl/i2c_nco_regmap.sv
// I2C slave register map driving a bank of NCO channel controls.
// Bytes written over I2C land in shadow registers; the whole shadow set is
// copied to the live outputs in a single clock when a write transaction that
// carried at least one data byte ends with STOP or repeated START.
//
// Bus handshake: the slave never drives sda high. It pulls sda low only for
// its own ACK bits and for 0 bits of read data. Every change to its sda
// drive is made while scl is low, a few clk after the synchronized falling
// edge of scl. START and STOP are recognised in every state and take
// priority over bit traffic.
//
// Register pointer: a pointer byte sets both the running pointer and a read
// base. A read transaction starts at the read base, so a write followed by a
// repeated-START read returns the bytes just written. The running pointer
// advances after every data byte and wraps from NUM_CH*16-1 back to 0.
module i2c_nco_regmap #(
  parameter logic [6:0] DEV_ADDR = 7'h75,
  parameter int         NUM_CH   = 2,
  parameter int         FREQ_W   = 64,
  parameter int         DUTY_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       scl,
  inout  wire                        sda,
  output logic [NUM_CH-1:0]          nco_enable,
  output logic [2*NUM_CH-1:0]        nco_wave,
  output logic [NUM_CH*FREQ_W-1:0]   nco_frequency,
  output logic [NUM_CH*DUTY_W-1:0]   nco_duty_cycle,
  output logic                       update,
  output logic                       busy,
  output logic                       rd_nack
);

  localparam int         FB       = FREQ_W / 8;
  localparam int         DB       = DUTY_W / 8;
  localparam logic [7:0] PTR_LAST = 8'(NUM_CH * 16 - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  // Synchronizers and edge history
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;

  // Protocol state
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       full_q, full_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] base_q, base_d;
  logic       wrote_q, wrote_d;
  logic       busy_q, busy_d;
  logic       rd_nack_q, rd_nack_d;
  logic       sda_oe_q, sda_oe_d;
  logic       update_q;

  // Datapath controls
  logic       wr_en;
  logic       commit;
  logic [7:0] ptr_inc;
  logic [7:0] rd_byte;

  // Shadow and live register banks
  logic [NUM_CH-1:0]        sh_en_q, live_en_q;
  logic [2*NUM_CH-1:0]      sh_wave_q, live_wave_q;
  logic [NUM_CH*FREQ_W-1:0] sh_freq_q, live_freq_q;
  logic [NUM_CH*DUTY_W-1:0] sh_duty_q, live_duty_q;

  // Two-stage synchronizers plus one stage of history for edge detection;
  // reset to the idle-bus level so no edge is seen on exit from reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign ptr_inc = (ptr_q == PTR_LAST) ? 8'd0 : ptr_q + 8'd1;

  // Read mux: implemented shadow bytes at the running pointer, zero elsewhere.
  always_comb begin
    rd_byte = 8'h00;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ptr_q[7:4] == 4'(n)) begin
        if (ptr_q[3:0] == 4'd0) rd_byte = {5'b00000, sh_wave_q[2*n +: 2], sh_en_q[n]};
        for (int k = 0; k < FB; k++)
          if (ptr_q[3:0] == 4'(k + 1)) rd_byte = sh_freq_q[n*FREQ_W + k*8 +: 8];
        for (int k = 0; k < DB; k++)
          if (ptr_q[3:0] == 4'(k + 9)) rd_byte = sh_duty_q[n*DUTY_W + k*8 +: 8];
      end
    end
  end

  // Next-state logic: START/STOP first, then per-state bit and byte handling.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    full_d    = full_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    ptr_d     = ptr_q;
    base_d    = base_q;
    wrote_d   = wrote_q;
    busy_d    = busy_q;
    rd_nack_d = rd_nack_q;
    wr_en     = 1'b0;
    commit    = 1'b0;

    if (start_det) begin
      commit    = wrote_q;
      wrote_d   = 1'b0;
      state_d   = ADDR;
      bit_cnt_d = 3'd7;
      full_d    = 1'b0;
      busy_d    = 1'b1;
      rd_nack_d = 1'b0;
    end else if (stop_det) begin
      commit  = wrote_q;
      wrote_d = 1'b0;
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            rx_d = {rx_q[6:0], sda_s};
            if (bit_cnt_q == 3'd0) full_d = 1'b1;
            else bit_cnt_d = bit_cnt_q - 3'd1;
          end else if (scl_fall && full_q) begin
            // 8th falling edge: the byte is complete.
            full_d    = 1'b0;
            bit_cnt_d = 3'd7;
            if (state_q == ADDR) begin
              if (rx_q[7:1] == DEV_ADDR) begin
                state_d = ADDR_ACK;
                rw_d    = rx_q[0];
                if (rx_q[0]) ptr_d = base_q;
              end else begin
                state_d = IDLE;
              end
            end else if (state_q == PTR) begin
              ptr_d   = rx_q;
              base_d  = rx_q;
              state_d = PTR_ACK;
            end else begin
              wr_en   = 1'b1;
              wrote_d = 1'b1;
              ptr_d   = ptr_inc;
              state_d = WDATA_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              state_d = RDATA;
              tx_d    = rd_byte;
            end else begin
              state_d = PTR;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) state_d = WDATA;
        end
        RDATA: begin
          if (scl_rise) begin
            if (bit_cnt_q == 3'd0) full_d = 1'b1;
            else bit_cnt_d = bit_cnt_q - 3'd1;
          end else if (scl_fall) begin
            if (full_q) begin
              full_d    = 1'b0;
              bit_cnt_d = 3'd7;
              ptr_d     = ptr_inc;
              tx_d      = 8'hFF;
              state_d   = RDATA_ACK;
            end else begin
              tx_d = {tx_q[6:0], 1'b1};
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            mack_d = sda_s;
          end else if (scl_fall) begin
            if (!mack_q) begin
              state_d = RDATA;
              tx_d    = rd_byte;
            end else begin
              rd_nack_d = 1'b1;
              state_d   = IDLE;
            end
          end
        end
        default: ;
      endcase
    end

    sda_oe_d = (state_d == ADDR_ACK) || (state_d == PTR_ACK) || (state_d == WDATA_ACK) ||
               ((state_d == RDATA) && !tx_d[7]);
  end

  // Protocol state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd7;
      full_q    <= 1'b0;
      rx_q      <= 8'h00;
      tx_q      <= 8'hFF;
      rw_q      <= 1'b0;
      mack_q    <= 1'b1;
      ptr_q     <= 8'h00;
      base_q    <= 8'h00;
      wrote_q   <= 1'b0;
      busy_q    <= 1'b0;
      rd_nack_q <= 1'b0;
      sda_oe_q  <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      full_q    <= full_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
      ptr_q     <= ptr_d;
      base_q    <= base_d;
      wrote_q   <= wrote_d;
      busy_q    <= busy_d;
      rd_nack_q <= rd_nack_d;
      sda_oe_q  <= sda_oe_d;
      update_q  <= commit;
    end
  end

  // Shadow writes: only implemented offsets store; everything else is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_en_q   <= '0;
      sh_wave_q <= '0;
      sh_freq_q <= '0;
      sh_duty_q <= '0;
    end else if (wr_en) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ptr_q[7:4] == 4'(n)) begin
          if (ptr_q[3:0] == 4'd0) begin
            sh_en_q[n]         <= rx_q[0];
            sh_wave_q[2*n +: 2] <= rx_q[2:1];
          end
          for (int k = 0; k < FB; k++)
            if (ptr_q[3:0] == 4'(k + 1)) sh_freq_q[n*FREQ_W + k*8 +: 8] <= rx_q;
          for (int k = 0; k < DB; k++)
            if (ptr_q[3:0] == 4'(k + 9)) sh_duty_q[n*DUTY_W + k*8 +: 8] <= rx_q;
        end
      end
    end
  end

  // Live registers take the whole shadow set in one clock on commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_en_q   <= '0;
      live_wave_q <= '0;
      live_freq_q <= '0;
      live_duty_q <= '0;
    end else if (commit) begin
      live_en_q   <= sh_en_q;
      live_wave_q <= sh_wave_q;
      live_freq_q <= sh_freq_q;
      live_duty_q <= sh_duty_q;
    end
  end

  assign sda            = sda_oe_q ? 1'b0 : 1'bz;
  assign nco_enable     = live_en_q;
  assign nco_wave       = live_wave_q;
  assign nco_frequency  = live_freq_q;
  assign nco_duty_cycle = live_duty_q;
  assign update         = update_q;
  assign busy           = busy_q;
  assign rd_nack        = rd_nack_q;

endmodule

// File: tb/tb_i2c_nco_regmap.sv
// Bench for i2c_nco_regmap: bit-banged I2C master, byte-array register model.
module tb_i2c_nco_regmap;

  localparam int NUM_CH = 2;
  localparam int FREQ_W = 64;
  localparam int DUTY_W = 16;
  localparam int LW     = NUM_CH * (3 + FREQ_W + DUTY_W);
  localparam int Q      = 5;

  logic clk, reset, scl, m_sda;
  wire  sda;
  logic [NUM_CH-1:0]        nco_enable;
  logic [2*NUM_CH-1:0]      nco_wave;
  logic [NUM_CH*FREQ_W-1:0] nco_frequency;
  logic [NUM_CH*DUTY_W-1:0] nco_duty_cycle;
  logic update, busy, rd_nack;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  wire [LW-1:0] live_bus = {nco_enable, nco_wave, nco_frequency, nco_duty_cycle};

  i2c_nco_regmap #(.DEV_ADDR(7'h75), .NUM_CH(NUM_CH), .FREQ_W(FREQ_W), .DUTY_W(DUTY_W)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .nco_enable(nco_enable), .nco_wave(nco_wave), .nco_frequency(nco_frequency),
    .nco_duty_cycle(nco_duty_cycle), .update(update), .busy(busy), .rd_nack(rd_nack)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int exp_upd = 0;
  int slave_low_cnt = 0;
  int glitch_cnt = 0;
  bit prev_scl = 1'b1;
  bit prev_low = 1'b0;
  bit cur_low;

  logic [7:0] m_shadow [256];
  logic [7:0] m_live   [256];
  logic [7:0] m_base;
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  // Bus monitor: update pulses, slave pull-downs, slave changes while scl high.
  always @(posedge clk) begin
    #1;
    if (update === 1'b1) upd_cnt++;
    cur_low = m_sda && (sda === 1'b0);
    if (cur_low) slave_low_cnt++;
    if (scl && prev_scl && (cur_low != prev_low)) glitch_cnt++;
    prev_scl = scl;
    prev_low = cur_low;
  end

  // ---------------- reference model ----------------
  function automatic bit impl(int a);
    int off = a % 16;
    return (a / 16 < NUM_CH) && (off == 0 || (off >= 1 && off <= FREQ_W / 8) ||
                                 (off >= 9 && off < 9 + DUTY_W / 8));
  endfunction

  function automatic int nxt(int a);
    return (a == NUM_CH * 16 - 1) ? 0 : (a + 1) % 256;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) begin m_shadow[i] = 8'h00; m_live[i] = 8'h00; end
    m_base = 8'h00;
  endfunction

  function automatic void model_wr(int a, logic [7:0] b);
    if (impl(a)) m_shadow[a] = (a % 16 == 0) ? (b & 8'h07) : b;
  endfunction

  function automatic logic [7:0] model_rd(int a);
    return impl(a) ? m_shadow[a] : 8'h00;
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < 256; i++) m_live[i] = m_shadow[i];
    exp_upd++;
  endfunction

  function automatic logic [LW-1:0] exp_live();
    logic [NUM_CH-1:0] en;
    logic [2*NUM_CH-1:0] wv;
    logic [NUM_CH*FREQ_W-1:0] fr;
    logic [NUM_CH*DUTY_W-1:0] du;
    for (int n = 0; n < NUM_CH; n++) begin
      en[n] = m_live[n*16][0];
      wv[2*n +: 2] = m_live[n*16][2:1];
      for (int k = 0; k < FREQ_W / 8; k++) fr[n*FREQ_W + k*8 +: 8] = m_live[n*16 + 1 + k];
      for (int k = 0; k < DUTY_W / 8; k++) du[n*DUTY_W + k*8 +: 8] = m_live[n*16 + 9 + k];
    end
    return {en, wv, fr, du};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; qwait(); scl = 1'b1; qwait(); m_sda = 1'b0; qwait(); scl = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qwait(); scl = 1'b1; qwait(); m_sda = 1'b1; qwait();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; qwait(); scl = 1'b1; qwait(); qwait(); scl = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, output bit acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; qwait(); scl = 1'b1; qwait();
    acked = (sda === 1'b0);
    qwait(); scl = 1'b0; qwait();
  endtask

  task automatic recv_byte(input bit nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; qwait(); scl = 1'b1; qwait(); b[i] = sda; qwait(); scl = 1'b0; qwait();
    end
    send_bit(nack);
    m_sda = 1'b1;
  endtask

  // START, write address, pointer, data bytes; leaves the bus held (scl low).
  task automatic wr_frame(input logic [7:0] ptr, input logic [7:0] data [$], output int acks);
    bit a;
    int p;
    acks = 0;
    i2c_start();
    send_byte(8'hEA, a); acks += int'(a);
    send_byte(ptr, a);   acks += int'(a);
    m_base = ptr;
    p = ptr;
    foreach (data[i]) begin
      send_byte(data[i], a); acks += int'(a);
      model_wr(p, data[i]);
      p = nxt(p);
    end
  endtask

  // START, read address, m bytes (last one NACKed); expectations go to exp_q.
  task automatic rd_frame(input int m, output bit addr_ack);
    logic [7:0] b;
    int p = m_base;
    i2c_start();
    send_byte(8'hEB, addr_ack);
    for (int i = 0; i < m; i++) begin
      exp_q.push_back(model_rd(p));
      p = nxt(p);
      recv_byte(i == m - 1, b);
      got_q.push_back(b);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    if (live_bus !== '0) begin errors++; $display("FAIL reset_live: got %h want 0", live_bus); end
    checks++;
    if ({update, busy, rd_nack} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {update, busy, rd_nack});
    end
    checks++;
    if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda); end
    checks++;
  endtask

  task automatic test_ctrl_write();
    int acks;
    wr_frame(8'h00, '{8'h07}, acks);
    if (acks != 3) begin errors++; $display("FAIL ctrl_acks: got %0d want 3", acks); end
    checks++;
    i2c_stop(); model_commit(); qwait();
    if (nco_enable[0] !== 1'b1 || nco_wave[1:0] !== 2'b11) begin
      errors++; $display("FAIL ctrl_out: got en=%b wave=%b want en=1 wave=11", nco_enable[0], nco_wave[1:0]);
    end
    checks++;
    if (upd_cnt != exp_upd) begin errors++; $display("FAIL ctrl_update: got %0d want %0d", upd_cnt, exp_upd); end
    checks++;
  endtask

  task automatic test_freq_write();
    int acks;
    wr_frame(8'h01, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, acks);
    if (live_bus !== exp_live() || upd_cnt != exp_upd) begin
      errors++; $display("FAIL freq_pending: got %h upd=%0d want %h upd=%0d", live_bus, upd_cnt, exp_live(), exp_upd);
    end
    checks++;
    i2c_stop(); model_commit(); qwait();
    if (nco_frequency[63:0] !== 64'h8877665544332211) begin
      errors++; $display("FAIL freq_out: got %h want 8877665544332211", nco_frequency[63:0]);
    end
    checks++;
    if (acks != 10) begin errors++; $display("FAIL freq_acks: got %0d want 10", acks); end
    checks++;
  endtask

  task automatic test_write_read();
    int acks;
    bit a;
    wr_frame(8'h09, '{8'h34, 8'h12}, acks);
    model_commit();
    rd_frame(3, a);
    i2c_stop(); qwait();
    if (nco_duty_cycle[15:0] !== 16'h1234 || upd_cnt != exp_upd) begin
      errors++; $display("FAIL wr_rd_commit: got duty=%h upd=%0d want duty=1234 upd=%0d", nco_duty_cycle[15:0], upd_cnt, exp_upd);
    end
    checks++;
    if (!a || acks != 4) begin errors++; $display("FAIL wr_rd_acks: got addr=%0d wr=%0d want 1 and 4", a, acks); end
    checks++;
    if (exp_q.size() != 3 || exp_q[0] !== 8'h34 || exp_q[1] !== 8'h12 || exp_q[2] !== 8'h00) begin
      errors++; $display("FAIL wr_rd_model: model expectations differ from 34 12 00");
    end
    checks++;
    while (exp_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      logic [7:0] g = got_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL wr_rd_data: got %h want %h", g, e); end
      checks++;
    end
    if (rd_nack !== 1'b1) begin errors++; $display("FAIL wr_rd_nack: got %b want 1", rd_nack); end
    checks++;
  endtask

  task automatic test_wrong_addr();
    bit a;
    int acks = 0;
    int low0 = slave_low_cnt;
    i2c_start();
    if (rd_nack !== 1'b0) begin errors++; $display("FAIL start_clears_nack: got %b want 0", rd_nack); end
    checks++;
    send_byte(8'hE8, a); acks += int'(a);
    send_byte(8'h00, a); acks += int'(a);
    send_byte(8'h07, a); acks += int'(a);
    if (busy !== 1'b1) begin errors++; $display("FAIL wrong_busy: got %b want 1", busy); end
    checks++;
    i2c_stop(); qwait();
    if (acks != 0 || slave_low_cnt != low0) begin
      errors++; $display("FAIL wrong_quiet: got acks=%0d lows=%0d want 0 0", acks, slave_low_cnt - low0);
    end
    checks++;
    if (busy !== 1'b0 || upd_cnt != exp_upd || live_bus !== exp_live()) begin
      errors++; $display("FAIL wrong_state: got busy=%b upd=%0d want busy=0 upd=%0d", busy, upd_cnt, exp_upd);
    end
    checks++;
  endtask

  task automatic test_wrap();
    int acks;
    wr_frame(8'h1F, '{8'hAA, 8'h05}, acks);
    i2c_stop(); model_commit(); qwait();
    if (nco_enable[0] !== 1'b1 || nco_wave[1:0] !== 2'b10 || live_bus !== exp_live()) begin
      errors++; $display("FAIL wrap_out: got en=%b wave=%b want en=1 wave=10", nco_enable[0], nco_wave[1:0]);
    end
    checks++;
    if (acks != 4) begin errors++; $display("FAIL wrap_acks: got %0d want 4", acks); end
    checks++;
  endtask

  task automatic test_reset_midway();
    bit a;
    int acks;
    int upd0;
    i2c_start();
    send_byte(8'hEA, a);
    send_byte(8'h10, a);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    upd0 = upd_cnt;
    reset = 1'b1; qwait();
    model_reset();
    if (live_bus !== '0 || busy !== 1'b0 || rd_nack !== 1'b0) begin
      errors++; $display("FAIL midreset_out: got %h busy=%b want 0", live_bus, busy);
    end
    checks++;
    reset = 1'b0; qwait();
    i2c_stop(); qwait();
    if (upd_cnt != upd0) begin errors++; $display("FAIL midreset_update: got %0d want %0d", upd_cnt, upd0); end
    checks++;
    wr_frame(8'h10, '{8'h03}, acks);
    i2c_stop(); model_commit(); qwait();
    if (acks != 3 || nco_enable !== 2'b10 || nco_wave !== 4'b0100) begin
      errors++; $display("FAIL midreset_after: got acks=%0d en=%b wave=%b want 3 10 0100", acks, nco_enable, nco_wave);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      int kind = $urandom_range(0, 3);
      int acks;
      int n;
      bit a;
      logic [7:0] data [$];
      if (kind <= 1) begin
        logic [7:0] ptr = 8'($urandom_range(0, 40));
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) data.push_back(8'($urandom));
        wr_frame(ptr, data, acks);
        if (acks != n + 2) begin errors++; $display("FAIL rnd_wr_acks t=%0d: got %0d want %0d", t, acks, n + 2); end
        checks++;
        if (n > 0) model_commit();
        if (kind == 1) rd_frame($urandom_range(1, 3), a);
        i2c_stop();
      end else if (kind == 2) begin
        rd_frame($urandom_range(1, 4), a);
        i2c_stop();
      end else begin
        logic [6:0] bad = 7'($urandom_range(0, 127));
        if (bad == 7'h75) bad = 7'h74;
        acks = 0;
        i2c_start();
        send_byte({bad, 1'($urandom)}, a); acks += int'(a);
        send_byte(8'($urandom), a); acks += int'(a);
        i2c_stop();
        if (acks != 0) begin errors++; $display("FAIL rnd_bad_ack t=%0d: got %0d want 0", t, acks); end
        checks++;
      end
      qwait();
      while (exp_q.size() > 0) begin
        logic [7:0] e = exp_q.pop_front();
        logic [7:0] g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL rnd_rd t=%0d: got %h want %h", t, g, e); end
        checks++;
      end
      if (live_bus !== exp_live() || upd_cnt != exp_upd) begin
        errors++; $display("FAIL rnd_live t=%0d: got %h upd=%0d want %h upd=%0d", t, live_bus, upd_cnt, exp_live(), exp_upd);
      end
      checks++;
    end
    if (glitch_cnt != 0) begin errors++; $display("FAIL sda_while_scl_high: got %0d want 0", glitch_cnt); end
    checks++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(negedge clk);
    test_reset();
    reset = 1'b0;
    qwait();
    test_reset();
    test_ctrl_write();
    test_freq_write();
    test_write_read();
    test_wrong_addr();
    test_wrap();
    test_reset_midway();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_nco_regmap.md
I2C_NCO_REGMAP -- requirements
Module: i2c_nco_regmap

Interface
REQ-001 Parameter DEV_ADDR, 7'h75, 7-bit I2C device address.
REQ-002 Parameter NUM_CH, 2, number of NCO channels (1..8).
REQ-003 Parameter FREQ_W, 64, frequency word width per channel (multiple of 8, 8..64).
REQ-004 Parameter DUTY_W, 16, duty word width per channel (multiple of 8, 8..16).
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 scl  input  1  I2C clock, asynchronous to clk.
REQ-008 sda  inout  1  I2C data, open-drain: driven 0 or high-Z, never driven 1.
REQ-009 nco_enable  output  NUM_CH  live per-channel enable.
REQ-010 nco_wave  output  2*NUM_CH  live waveform select, channel n at [2n+1:2n].
REQ-011 nco_frequency  output  NUM_CH*FREQ_W  live frequency words, channel n at [n*FREQ_W +: FREQ_W].
REQ-012 nco_duty_cycle  output  NUM_CH*DUTY_W  live duty words, channel n at [n*DUTY_W +: DUTY_W].
REQ-013 update  output  1  one-clk pulse when shadow registers are committed to live outputs.
REQ-014 busy  output  1  high from START to STOP on the bus, any address.
REQ-015 rd_nack  output  1  high after master NACKs a read byte; cleared at next START.

Function
REQ-016 scl and sda each pass a 2-flop synchronizer; edges, START (sda fall while scl high) and STOP (sda rise while scl high) are detected on synchronized values.
REQ-017 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-018 START or repeated START from any state -> ADDR, bit counter 7; STOP from any state -> IDLE.
REQ-019 Bits sampled on scl rising edge, MSB first; byte complete on 8th scl falling edge.
REQ-020 ADDR byte [7:1]==DEV_ADDR -> ADDR_ACK (drive sda=0 for the ACK bit); mismatch -> IDLE, sda never driven, until next START.
REQ-021 After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA.
REQ-022 PTR byte loads 8-bit pointer, ACKed -> WDATA; each WDATA byte written to shadow[pointer], ACKed, pointer incremented.
REQ-023 Map per channel n, base n*16: +0 ctrl {reserved[7:3], wave[2:1], enable[0]}; +1..+FREQ_W/8 frequency bytes LSB first; +9..+9+DUTY_W/8-1 duty bytes LSB first; other offsets reserved.
REQ-024 Pointer wraps from NUM_CH*16-1 to 0.
REQ-025 Writes to reserved offsets or pointer >= NUM_CH*16 are ACKed and discarded; reads there return 8'h00.
REQ-026 RDATA shifts shadow[pointer] out MSB first; sda changes only while scl low, within 4 clk after scl falling edge; pointer increments after each byte.
REQ-027 RDATA_ACK: sda released; master ACK (0) -> RDATA next byte; NACK (1) -> set rd_nack, stop driving until STOP/START.
REQ-028 Commit: on STOP, or repeated START, ending a write transaction with >=1 WDATA byte, all shadow registers copy to live outputs in one clk and update pulses that clk.
REQ-029 Transactions with no WDATA byte, read transactions, and mismatched addresses never commit or pulse update.
REQ-030 Reads return shadow (pending) values, not live values.
REQ-031 Slave releases sda at the scl falling edge ending each ACK bit.

Reset
REQ-032 reset asserted: state IDLE, sda high-Z, pointer 0, all shadow and live registers 0, update 0, busy 0, rd_nack 0.
REQ-033 reset mid-transaction aborts with no commit; slave ignores bus until next START.

Verification
VER-001 Write 0xEA,0x00,0x07 then STOP (NUM_CH=2) -> ACK on all 3 bytes; after STOP nco_enable[0]=1, nco_wave[1:0]=2'b11, update one clk.
VER-002 Write 0xEA,0x01,0x11..0x88 (8 bytes), STOP -> nco_frequency[63:0]=64'h8877665544332211; outputs unchanged until STOP.
VER-003 Write 0xEA,0x09,0x34,0x12; repeated START; 0xEB; read 3 bytes, ACK,ACK,NACK -> commit at repeated START, duty ch0=16'h1234, read data 0x34,0x12,0x00 (offset 11 reserved), rd_nack=1.
VER-004 Address 0xE8 followed by data bytes -> no ACK, sda never driven, no update, busy=1 until STOP.
VER-005 Write 0xEA,0x1F,0xAA,0x05, STOP -> 0xAA discarded (reserved), pointer wraps to 0, nco_enable[0]=1, nco_wave[1:0]=2'b10.
VER-006 reset asserted after 3 data bits of a WDATA byte -> all outputs 0, no update; following valid write succeeds.
